// File: rtl/firing_dispatch_fsm.sv
// firing_dispatch_fsm: sequences command fetch or one-hot dispatch of a mode FSM,
// forwarding partial/final results and error words into the output FIFO.
module firing_dispatch_fsm #(
  parameter int word_size = 16,
  parameter int NUM_MODES = 4,
  parameter int OP_W = 8,
  parameter logic [NUM_MODES-1:0] NOOUT_MASK = 4'b1000,
  parameter int TMO_W = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_fsm,
  input  logic [1:0]                       next_instr,
  input  logic [OP_W-1:0]                  instr,
  output logic                             en_get_command,
  input  logic                             done_get_cmd,
  output logic [NUM_MODES-1:0]             child_start,
  output logic [NUM_MODES-1:0]             child_abort,
  input  logic [NUM_MODES-1:0]             child_done,
  input  logic [NUM_MODES-1:0]             child_partial,
  input  logic [NUM_MODES*2*word_size-1:0] child_result,
  input  logic [NUM_MODES*2*word_size-1:0] child_status,
  input  logic [TMO_W-1:0]                 tmo_limit,
  input  logic                             out_full,
  output logic                             en_wr_output_fifo,
  output logic [2*word_size-1:0]           result,
  output logic [2*word_size-1:0]           status,
  output logic                             done_fsm,
  output logic                             busy,
  output logic [1:0]                       err_code
);
  localparam int RW = 2*word_size;
  localparam int KW = $clog2(NUM_MODES);
  typedef enum logic [3:0] {
    IDLE, CMD_START, CMD_WAIT, CMD_DONE, RUN_START, RUN_WAIT, FINAL_WR, ERR_WR, DONE
  } state_t;
  state_t state, state_n;
  logic [KW-1:0] k;
  logic pend, pend_n, fin_v, err_arm, abort_v;
  logic [RW-1:0] part_res, part_sts, fin_res, fin_sts, k_res, k_sts;
  logic [TMO_W-1:0] cnt, cnt_inc;
  logic [NUM_MODES-1:0] k_oh;
  logic go_setup, go_instr, legal, waiting, tmo_hit, cmd_tmo, run_tmo, dn, pt, wr_state;
  always_comb begin
    k_oh = {{(NUM_MODES-1){1'b0}}, 1'b1} << k;
    k_res = child_result[k*RW +: RW];
    k_sts = child_status[k*RW +: RW];
    go_setup = state == IDLE && start_fsm && next_instr == 2'b00;
    go_instr = state == IDLE && start_fsm && next_instr == 2'b01;
    legal = int'(instr) < NUM_MODES;
    waiting = state == CMD_WAIT || state == RUN_WAIT;
    cnt_inc = cnt + 1'b1;
    tmo_hit = tmo_limit != '0 && cnt_inc == tmo_limit;
    cmd_tmo = state == CMD_WAIT && !done_get_cmd && tmo_hit;
    // a completion in the same cycle as the timeout takes precedence
    run_tmo = state == RUN_WAIT && !fin_v && !child_done[k] && tmo_hit;
    dn = state == RUN_WAIT && !fin_v && child_done[k];
    pt = state == RUN_WAIT && child_partial[k];
    wr_state = state == FINAL_WR || (state == ERR_WR && !err_arm);
    en_wr_output_fifo = (wr_state || pend) && !out_full;
    pend_n = run_tmo ? 1'b0 : (pend && out_full) || (pt && !pend);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = go_setup ? CMD_START : go_instr ? (legal ? RUN_START : ERR_WR) : IDLE;
      CMD_START: state_n = CMD_WAIT;
      CMD_WAIT:  state_n = done_get_cmd ? CMD_DONE : cmd_tmo ? ERR_WR : CMD_WAIT;
      CMD_DONE:  state_n = IDLE;
      RUN_START: state_n = RUN_WAIT;
      RUN_WAIT:  state_n = run_tmo ? ERR_WR :
                           ((fin_v || dn) && !pend_n) ? (NOOUT_MASK[k] ? DONE : FINAL_WR) : RUN_WAIT;
      FINAL_WR:  state_n = out_full ? FINAL_WR : DONE;
      ERR_WR:    state_n = (!err_arm && !out_full) ? DONE : ERR_WR;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    en_get_command = state == CMD_START;
    done_fsm = state == CMD_DONE || state == DONE;
    child_start = state == RUN_START ? k_oh : '0;
    child_abort = abort_v ? k_oh : '0;
    result = state == ERR_WR ? '0 : state == FINAL_WR ? fin_res : pend ? part_res : '0;
    status = state == ERR_WR ? {1'b1, {(RW-3){1'b0}}, err_code} :
             state == FINAL_WR ? fin_sts : pend ? part_sts : '0;
  end
  // ERR_WR spends its first cycle on the abort pulse before writing the error word
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      pend <= 1'b0;
      fin_v <= 1'b0;
      err_arm <= 1'b0;
      abort_v <= 1'b0;
      part_res <= '0;
      part_sts <= '0;
      fin_res <= '0;
      fin_sts <= '0;
      cnt <= '0;
      err_code <= 2'd0;
    end else begin
      state <= state_n;
      pend <= pend_n;
      fin_v <= state == RUN_WAIT && (fin_v || dn);
      err_arm <= state_n == ERR_WR && state != ERR_WR;
      abort_v <= run_tmo;
      cnt <= waiting ? cnt_inc : '0;
      if (go_instr) k <= instr[KW-1:0];
      if (pt && !pend) begin
        part_res <= k_res;
        part_sts <= k_sts;
      end
      if (dn) begin
        fin_res <= k_res;
        fin_sts <= k_sts;
      end
      if (go_setup || go_instr) err_code <= (go_instr && !legal) ? 2'd1 : 2'd0;
      else if (cmd_tmo || run_tmo) err_code <= 2'd2;
      else if (pt && pend) err_code <= 2'd3;
    end
  end
endmodule

// File: tb/tb_firing_dispatch_fsm.sv
// tb_firing_dispatch_fsm: directed and randomized firings against a write-order model.
module tb_firing_dispatch_fsm;
  localparam int NM = 4;
  localparam int RW = 32;
  logic clk = 0, rst = 1, start_fsm = 0, done_get_cmd = 0, out_full = 0;
  logic [1:0] next_instr = 0;
  logic [7:0] instr = 0;
  logic en_get_command, en_wr_output_fifo, done_fsm, busy;
  logic [NM-1:0] child_start, child_abort, child_done = 0, child_partial = 0;
  logic [NM*RW-1:0] child_result = '0, child_status = '0;
  logic [15:0] tmo_limit = 0;
  logic [RW-1:0] result, status;
  logic [1:0] err_code;
  int n_chk = 0, n_fail = 0;
  logic [63:0] exp_q[$], obs_q[$];
  int done_cnt, start_cnt, abort_cnt, gc_cnt, done_cyc, cs;
  logic [NM-1:0] start_seen, abort_seen;

  always #5 clk = ~clk;

  firing_dispatch_fsm dut (
    .clk(clk), .rst(rst), .start_fsm(start_fsm), .next_instr(next_instr), .instr(instr),
    .en_get_command(en_get_command), .done_get_cmd(done_get_cmd),
    .child_start(child_start), .child_abort(child_abort), .child_done(child_done),
    .child_partial(child_partial), .child_result(child_result), .child_status(child_status),
    .tmo_limit(tmo_limit), .out_full(out_full), .en_wr_output_fifo(en_wr_output_fifo),
    .result(result), .status(status), .done_fsm(done_fsm), .busy(busy), .err_code(err_code)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    exp_q.delete(); obs_q.delete();
    done_cnt = 0; start_cnt = 0; abort_cnt = 0; gc_cnt = 0;
    done_cyc = -1; cs = -1; start_seen = 0; abort_seen = 0;
  endtask

  // sample mid-cycle, then advance to just after the next rising edge
  task automatic tick(input int cyc);
    @(negedge clk);
    if (en_wr_output_fifo) obs_q.push_back({result, status});
    if (done_fsm) begin done_cnt++; done_cyc = cyc; end
    if (|child_start) begin start_cnt++; start_seen = child_start; if (cs < 0) cs = cyc; end
    if (|child_abort) begin abort_cnt++; abort_seen = child_abort; end
    if (en_get_command) gc_cnt++;
    @(posedge clk); #1;
  endtask

  // one INSTR firing; the bench plays child op: partials at p0+pgap*i, done at lat (-1 = never)
  task automatic exec(input logic [7:0] op, input int lat, input int np, input int p0,
                      input int pgap, input int fs, input int fl, input int rst_at);
    logic [NM-1:0] oh;
    logic [RW-1:0] r, s;
    int rel;
    int ptimes[$];
    oh = (op < NM) ? (NM'(1) << op) : '0;
    for (int p = 0; p < np; p++) ptimes.push_back(p0 + pgap*p);
    clr();
    next_instr = 2'b01; instr = op; start_fsm = 1;
    @(posedge clk); #1;
    start_fsm = 0; next_instr = 2'($urandom);
    for (int cyc = 1; cyc < 300 && done_cnt == 0; cyc++) begin
      rel = (cs < 0) ? -1 : cyc - cs;
      r = $urandom; s = $urandom;
      child_result = {$urandom, $urandom, $urandom, $urandom};
      child_status = {$urandom, $urandom, $urandom, $urandom};
      child_done = NM'($urandom) & ~oh;
      child_partial = NM'($urandom) & ~oh;
      if (op < NM) begin
        child_result[op*RW +: RW] = r;
        child_status[op*RW +: RW] = s;
      end
      out_full = rel >= fs && rel < fs + fl;
      foreach (ptimes[i]) if (ptimes[i] == rel) begin
        child_partial |= oh; exp_q.push_back({r, s});
      end
      if (rel > 0 && rel == lat) begin
        child_done |= oh;
        if (op != 3) exp_q.push_back({r, s});
      end
      if (cyc == rst_at) rst = 1;
      tick(cyc);
      if (rst) begin rst = 0; break; end
    end
    child_done = 0; child_partial = 0; out_full = 0;
  endtask

  task automatic check_run(input string tag, input logic [1:0] exp_err);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_n_writes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), obs_q[i], exp_q[i]);
    chk({tag, "_err_code"}, err_code, exp_err);
  endtask

  initial begin
    int g;
    int op, np, p0, pgap, lat;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done_fsm, en_wr_output_fifo, en_get_command, child_start,
                          child_abort, err_code, result, status}, '0);
    rst = 0;

    // SETUP: done_get_cmd four cycles after en_get_command
    clr(); g = -1;
    next_instr = 2'b00; start_fsm = 1;
    @(posedge clk); #1;
    start_fsm = 0;
    for (int cyc = 1; cyc < 50 && done_cnt == 0; cyc++) begin
      done_get_cmd = g > 0 && cyc == g + 4;
      tick(cyc);
      if (gc_cnt == 1 && g < 0) g = cyc;
    end
    done_get_cmd = 0;
    chk("setup_gc_cycle", g, 1);
    chk("setup_gc_cnt", gc_cnt, 1);
    chk("setup_done_cycle", done_cyc, 6);
    check_run("setup", 2'd0);

    // single final result, minimum latency
    exec(8'd1, 5, 0, 1, 4, 0, 0, 0);
    chk("instr1_start_cycle", cs, 1);
    chk("instr1_start_cnt", start_cnt, 1);
    chk("instr1_start_vec", start_seen, 4'b0010);
    chk("instr1_done_cycle", done_cyc, 8);
    check_run("instr1", 2'd0);

    // three partials, FIFO full for three cycles over the second
    exec(8'd2, 12, 3, 1, 5, 7, 3, 0);
    check_run("partials", 2'd0);

    // illegal opcode
    exec(8'd9, -1, 0, 1, 4, 0, 0, 0);
    exp_q.push_back({32'h0, 32'h8000_0001});
    chk("illegal_start_cnt", start_cnt, 0);
    chk("illegal_done_cycle", done_cyc, 3);
    check_run("illegal", 2'd1);

    // watchdog: the second partial is stuck behind out_full when the timeout hits
    tmo_limit = 16'd10;
    exec(8'd0, -1, 2, 1, 8, 10, 3, 0);
    void'(exp_q.pop_back());
    exp_q.push_back({32'h0, 32'h8000_0002});
    chk("tmo_abort_cnt", abort_cnt, 1);
    chk("tmo_abort_vec", abort_seen, 4'b0001);
    check_run("timeout", 2'd2);
    tmo_limit = 16'd200;

    // no-output mode
    exec(8'd3, 4, 0, 1, 4, 0, 0, 0);
    chk("noout_done_cycle", done_cyc, 6);
    check_run("noout", 2'd0);

    // reset during RUN_WAIT
    exec(8'd3, -1, 0, 1, 4, 0, 0, 5);
    chk("rst_outputs", {busy, done_fsm, en_wr_output_fifo, en_get_command, child_start,
                        child_abort, err_code, result, status}, '0);
    chk("rst_n_writes", obs_q.size(), 0);
    chk("rst_done_cnt", done_cnt, 0);

    // randomized legal firings with partials and short stalls
    for (int t = 0; t < 8; t++) begin
      op = $urandom_range(0, 2);
      np = $urandom_range(0, 3);
      p0 = $urandom_range(1, 2);
      pgap = 4 + $urandom_range(0, 2);
      lat = np > 0 ? p0 + pgap*(np-1) + $urandom_range(0, 3) : $urandom_range(1, 6);
      exec(8'(op), lat, np, p0, pgap, $urandom_range(1, lat + 2), $urandom_range(0, 2), 0);
      chk($sformatf("rand%0d_start_vec", t), start_seen, NM'(1) << op);
      check_run($sformatf("rand%0d", t), 2'd0);
    end

    // randomized illegal opcode
    exec(8'($urandom_range(4, 255)), -1, 0, 1, 4, 0, 0, 0);
    exp_q.push_back({32'h0, 32'h8000_0001});
    check_run("rand_illegal", 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
